// File: rtl/handwash_valve_controller.sv
// Drives the handwash water valve from the sensor stage's waterOn request.
// Debounces the request, holds water briefly after release, caps run time and locks out re-arming.
module handwash_valve_controller #(
  parameter int ON_DEBOUNCE = 50000,
  parameter int OFF_HOLD    = 5000000,
  parameter int MAX_ON      = 600000000,
  parameter int LOCKOUT     = 20000000,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waterOn,
  input  logic        enable,
  output logic        valveOpen,
  output logic        timeoutPulse,
  output logic [15:0] washCount,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(ON_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(OFF_HOLD - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] LOCK_DONE = CNT_W'(LOCKOUT);

  // phase_cnt is shared: debounce samples in ARM, low samples in HOLD, elapsed cycles in LOCKOUT.
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             hold_expired;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // In OPEN the current low sample is the first one, so only OFF_HOLD == 1 expires there.
  assign hold_expired = (state == S_HOLD && phase_cnt == HOLD_LAST) ||
                        (state == S_OPEN && OFF_HOLD == 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      valveOpen    <= 1'b0;
      timeoutPulse <= 1'b0;
      washCount    <= '0;
      phase_cnt    <= '0;
      run_cnt      <= '0;
    end else begin
      // NOTE: non-blocking default here; any later assignment in this block wins for this edge.
      timeoutPulse <= 1'b0;
      if (!enable) begin
        state     <= S_IDLE;
        valveOpen <= 1'b0;
        phase_cnt <= '0;
        run_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (waterOn) begin
              run_cnt <= '0;
              if (ON_DEBOUNCE == 1) begin
                state     <= S_OPEN;
                valveOpen <= 1'b1;
                phase_cnt <= '0;
              end else begin
                state     <= S_ARM;
                phase_cnt <= CNT_ONE;
              end
            end
          end

          S_ARM: begin
            if (!waterOn) begin
              state     <= S_IDLE;
              phase_cnt <= '0;
            end else if (phase_cnt == DEB_LAST) begin
              state     <= S_OPEN;
              valveOpen <= 1'b1;
              phase_cnt <= '0;
              run_cnt   <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_ONE;
            end
          end

          S_OPEN, S_HOLD: begin
            if (run_cnt == RUN_LAST) begin
              // Timeout wins over a coincident hold expiry.
              state        <= S_LOCKOUT;
              valveOpen    <= 1'b0;
              timeoutPulse <= 1'b1;
              washCount    <= sat_inc(washCount);
              phase_cnt    <= '0;
              run_cnt      <= '0;
            end else if (waterOn) begin
              state     <= S_OPEN;
              phase_cnt <= '0;
              run_cnt   <= run_cnt + CNT_ONE;
            end else if (hold_expired) begin
              state     <= S_LOCKOUT;
              valveOpen <= 1'b0;
              washCount <= sat_inc(washCount);
              phase_cnt <= '0;
              run_cnt   <= '0;
            end else begin
              state     <= S_HOLD;
              phase_cnt <= (state == S_OPEN) ? CNT_ONE : phase_cnt + CNT_ONE;
              run_cnt   <= run_cnt + CNT_ONE;
            end
          end

          S_LOCKOUT: begin
            // A request still present after the lockout keeps us here until it drops.
            if (phase_cnt == LOCK_DONE) begin
              if (!waterOn) begin
                state     <= S_IDLE;
                phase_cnt <= '0;
              end
            end else begin
              phase_cnt <= phase_cnt + CNT_ONE;
            end
          end

          default: begin
            state     <= S_IDLE;
            valveOpen <= 1'b0;
            phase_cnt <= '0;
            run_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
